// File: rtl/vga_sync_if.sv
// VGA timing bundle: pixel enable, coordinates, blanking qualifier and syncs.
// The timing generator drives it (master); pixel/overlay stages consume it (slave).
interface vga_sync_if;
   logic       p_tick;
   logic [9:0] x;
   logic [9:0] y;
   logic       video_on;
   logic       hsync;
   logic       vsync;
   logic       frame_start;

   modport master (
      output p_tick, x, y, video_on, hsync, vsync, frame_start
   );

   modport slave (
      input  p_tick, x, y, video_on, hsync, vsync, frame_start
   );
endinterface

// File: rtl/vga_sync.sv
// 640x480@60 VGA timing generator running off the board clock.
// A DIV-clock divider produces the pixel enable; x/y advance on that enable,
// and the sync/blank outputs are registered one clock behind the counters.
module vga_sync #(
   parameter int DIV    = 4,
   parameter int H_VIS  = 640,
   parameter int H_FP   = 16,
   parameter int H_SYNC = 96,
   parameter int H_BP   = 48,
   parameter int V_VIS  = 480,
   parameter int V_FP   = 10,
   parameter int V_SYNC = 2,
   parameter int V_BP   = 33
) (
   input  logic       clk,
   input  logic       rst,
   vga_sync_if.master vga
);

   localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
   localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;
   // Keep the divider at least one bit wide so DIV=1 still elaborates.
   localparam int TW    = (DIV > 1) ? $clog2(DIV) : 1;

   localparam logic [TW-1:0] T_LAST  = TW'(DIV - 1);
   localparam logic [9:0]    H_LAST  = 10'(H_TOT - 1);
   localparam logic [9:0]    V_LAST  = 10'(V_TOT - 1);
   localparam logic [9:0]    H_VISW  = 10'(H_VIS);
   localparam logic [9:0]    V_VISW  = 10'(V_VIS);
   localparam logic [9:0]    HS_BEG  = 10'(H_VIS + H_FP);
   localparam logic [9:0]    HS_END  = 10'(H_VIS + H_FP + H_SYNC);
   localparam logic [9:0]    VS_BEG  = 10'(V_VIS + V_FP);
   localparam logic [9:0]    VS_END  = 10'(V_VIS + V_FP + V_SYNC);

   logic [TW-1:0] tcnt_q, tcnt_d;
   logic [9:0]    x_q, x_d;
   logic [9:0]    y_q, y_d;
   logic          p_tick_q, p_tick_d;
   logic          frame_start_q, frame_start_d;
   logic          hsync_q, hsync_d;
   logic          vsync_q, vsync_d;
   logic          video_on_q, video_on_d;

   // Next-state: divider, raster counters, and sync/blank decode of current x/y.
   always_comb begin
      tcnt_d = (tcnt_q == T_LAST) ? '0 : tcnt_q + 1'b1;
      // Registered from the next divider value so p_tick is high exactly
      // while tcnt sits at its last count.
      p_tick_d = (tcnt_d == T_LAST);

      x_d = x_q;
      y_d = y_q;
      if (p_tick_q) begin
         if (x_q == H_LAST) begin
            x_d = '0;
            y_d = (y_q == V_LAST) ? '0 : y_q + 10'd1;
         end else begin
            x_d = x_q + 10'd1;
         end
      end

      // Flags the pixel-enable cycle whose closing edge wraps both counters.
      frame_start_d = p_tick_d && (x_d == H_LAST) && (y_d == V_LAST);

      hsync_d    = !((x_q >= HS_BEG) && (x_q < HS_END));
      vsync_d    = !((y_q >= VS_BEG) && (y_q < VS_END));
      video_on_d = (x_q < H_VISW) && (y_q < V_VISW);
   end

   // State and output registers; reset forces syncs inactive and blanks video.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tcnt_q        <= '0;
         x_q           <= '0;
         y_q           <= '0;
         p_tick_q      <= 1'b0;
         frame_start_q <= 1'b0;
         hsync_q       <= 1'b1;
         vsync_q       <= 1'b1;
         video_on_q    <= 1'b0;
      end else begin
         tcnt_q        <= tcnt_d;
         x_q           <= x_d;
         y_q           <= y_d;
         p_tick_q      <= p_tick_d;
         frame_start_q <= frame_start_d;
         hsync_q       <= hsync_d;
         vsync_q       <= vsync_d;
         video_on_q    <= video_on_d;
      end
   end

   assign vga.p_tick      = p_tick_q;
   assign vga.x           = x_q;
   assign vga.y           = y_q;
   assign vga.video_on    = video_on_q;
   assign vga.hsync       = hsync_q;
   assign vga.vsync       = vsync_q;
   assign vga.frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_sync.sv
// Bench for vga_sync: a default-timing instance and a shrunk-raster instance
// share clock and reset. A producer pushes the expected outputs for each
// cycle (derived from the edge count since reset), a monitor pops and
// compares on the falling edge; directed checks cover reset and sync edges.
module tb_vga_sync;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   vga_sync_if if_d ();
   vga_sync_if if_s ();

   vga_sync u_def (
      .clk (clk),
      .rst (rst),
      .vga (if_d)
   );

   vga_sync #(
      .DIV(2), .H_VIS(8), .H_FP(1), .H_SYNC(2), .H_BP(1),
      .V_VIS(4), .V_FP(1), .V_SYNC(1), .V_BP(1)
   ) u_sml (
      .clk (clk),
      .rst (rst),
      .vga (if_s)
   );

   typedef struct packed {
      logic       p_tick;
      logic [9:0] x;
      logic [9:0] y;
      logic       video_on;
      logic       hsync;
      logic       vsync;
      logic       frame_start;
   } obs_t;

   int   n_chk  = 0;
   int   n_fail = 0;
   int   k      = 0;
   obs_t q_d[$];
   obs_t q_s[$];

   // Expected outputs after k clock edges since reset release.
   // Pixel count = floor(k/div); syncs reflect the position one edge earlier.
   function automatic obs_t model(int kk, int dv, int hv, int hfp, int hs, int hbp,
                                  int vv, int vfp, int vs, int vbp);
      obs_t o;
      int ht, vt, pix, px, xp, yp;
      ht  = hv + hfp + hs + hbp;
      vt  = vv + vfp + vs + vbp;
      pix = kk / dv;
      o.x = 10'(pix % ht);
      o.y = 10'((pix / ht) % vt);
      o.p_tick = ((kk % dv) == dv - 1);
      o.frame_start = o.p_tick && (int'(o.x) == ht - 1) && (int'(o.y) == vt - 1);
      if (kk == 0) begin
         o.hsync = 1'b1; o.vsync = 1'b1; o.video_on = 1'b0;
      end else begin
         px = (kk - 1) / dv;
         xp = px % ht;
         yp = (px / ht) % vt;
         o.hsync    = !(xp >= hv + hfp && xp < hv + hfp + hs);
         o.vsync    = !(yp >= vv + vfp && yp < vv + vfp + vs);
         o.video_on = (xp < hv) && (yp < vv);
      end
      return o;
   endfunction

   task automatic chk(string nm, int act, int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
      end
   endtask

   task automatic cmp_obs(string nm, int kk, obs_t g, obs_t e);
      n_chk++;
      if (g !== e) begin
         n_fail++;
         $display("FAIL %s k=%0d: got pt=%b x=%0d y=%0d von=%b hs=%b vs=%b fs=%b, expected pt=%b x=%0d y=%0d von=%b hs=%b vs=%b fs=%b",
                  nm, kk, g.p_tick, g.x, g.y, g.video_on, g.hsync, g.vsync, g.frame_start,
                  e.p_tick, e.x, e.y, e.video_on, e.hsync, e.vsync, e.frame_start);
      end
   endtask

   // Producer: track edges since release and queue the expected response.
   always @(posedge clk) begin
      if (rst) k = 0;
      else     k = k + 1;
      q_d.push_back(model(k, 4, 640, 16, 96, 48, 480, 10, 2, 33));
      q_s.push_back(model(k, 2, 8, 1, 2, 1, 4, 1, 1, 1));
   end

   // Monitor: every falling edge pop the expectation and compare all outputs.
   always @(negedge clk) begin
      obs_t g, e;
      if (q_d.size() > 0) begin
         e = q_d.pop_front();
         g = '{if_d.p_tick, if_d.x, if_d.y, if_d.video_on, if_d.hsync, if_d.vsync, if_d.frame_start};
         cmp_obs("sb_def", k, g, e);
      end
      if (q_s.size() > 0) begin
         e = q_s.pop_front();
         g = '{if_s.p_tick, if_s.x, if_s.y, if_s.video_on, if_s.hsync, if_s.vsync, if_s.frame_start};
         cmp_obs("sb_sml", k, g, e);
      end
   end

   // Hand-computed snapshots of the small raster (12x7 pixels, DIV=2).
   typedef struct {
      int   kk;
      obs_t o;
   } vec_t;

   vec_t tbl[10] = '{
      '{1,   '{1'b1, 10'd0,  10'd0, 1'b1, 1'b1, 1'b1, 1'b0}},
      '{17,  '{1'b1, 10'd8,  10'd0, 1'b0, 1'b1, 1'b1, 1'b0}},
      '{19,  '{1'b1, 10'd9,  10'd0, 1'b0, 1'b0, 1'b1, 1'b0}},
      '{23,  '{1'b1, 10'd11, 10'd0, 1'b0, 1'b1, 1'b1, 1'b0}},
      '{24,  '{1'b0, 10'd0,  10'd1, 1'b0, 1'b1, 1'b1, 1'b0}},
      '{25,  '{1'b1, 10'd0,  10'd1, 1'b1, 1'b1, 1'b1, 1'b0}},
      '{121, '{1'b1, 10'd0,  10'd5, 1'b0, 1'b1, 1'b0, 1'b0}},
      '{145, '{1'b1, 10'd0,  10'd6, 1'b0, 1'b1, 1'b1, 1'b0}},
      '{167, '{1'b1, 10'd11, 10'd6, 1'b0, 1'b1, 1'b1, 1'b1}},
      '{168, '{1'b0, 10'd0,  10'd0, 1'b0, 1'b1, 1'b1, 1'b0}}
   };

   initial begin
      int fall_k, rise_k, von_fall, hlow, fs_cnt, fs_last;
      obs_t g;
      fall_k = -1; rise_k = -1; von_fall = -1; hlow = 0; fs_cnt = 0; fs_last = -1;

      // Power-on reset values.
      #1 rst = 1'b1;
      #1;
      chk("por_x", int'(if_d.x), 0);
      chk("por_hsync", int'(if_d.hsync), 1);
      chk("por_vsync", int'(if_d.vsync), 1);
      chk("por_video_on", int'(if_d.video_on), 0);
      chk("por_p_tick", int'(if_d.p_tick), 0);
      chk("por_frame_start", int'(if_s.frame_start), 0);
      repeat (3) @(posedge clk);
      #3 rst = 1'b0;

      // Run mid-frame, then hit reset between edges and look immediately.
      repeat (1000) @(posedge clk);
      #7 rst = 1'b1;
      #1;
      chk("arst_x_def", int'(if_d.x), 0);
      chk("arst_video_on_def", int'(if_d.video_on), 0);
      chk("arst_x_sml", int'(if_s.x), 0);
      chk("arst_y_sml", int'(if_s.y), 0);
      chk("arst_hsync_sml", int'(if_s.hsync), 1);
      chk("arst_vsync_def", int'(if_d.vsync), 1);
      chk("arst_video_on_sml", int'(if_s.video_on), 0);
      @(posedge clk);
      #3 rst = 1'b0;

      for (int i = 1; i <= 3300; i++) begin
         @(posedge clk);
         #1;
         if (i <= 4) chk($sformatf("post_rst_p_tick_%0d", i), int'(if_d.p_tick), (i == 3) ? 1 : 0);
         if (i == 1) chk("post_rst_video_on", int'(if_d.video_on), 1);
         if (i == 4) chk("post_rst_x1", int'(if_d.x), 1);
         if (i == 3199) begin
            chk("line_end_x", int'(if_d.x), 799);
            chk("line_end_y", int'(if_d.y), 0);
         end
         if (i == 3200) begin
            chk("line_wrap_x", int'(if_d.x), 0);
            chk("line_wrap_y", int'(if_d.y), 1);
         end
         if (i <= 3200 && !if_d.hsync) hlow++;
         if (fall_k < 0 && !if_d.hsync) fall_k = i;
         if (fall_k >= 0 && rise_k < 0 && if_d.hsync) rise_k = i;
         if (von_fall < 0 && !if_d.video_on) von_fall = i;

         if (if_s.frame_start) begin
            if (fs_last < 0) chk("fs_first_k", i, 167);
            else             chk("fs_period", i - fs_last, 168);
            fs_last = i;
            fs_cnt++;
         end

         for (int j = 0; j < 10; j++) begin
            if (tbl[j].kk == i) begin
               g = '{if_s.p_tick, if_s.x, if_s.y, if_s.video_on, if_s.hsync, if_s.vsync, if_s.frame_start};
               cmp_obs("vec_sml", i, g, tbl[j].o);
            end
         end
      end

      chk("hsync_fall_k", fall_k, 2625);
      chk("hsync_rise_k", rise_k, 3009);
      chk("hsync_low_clks", hlow, 384);
      chk("video_on_fall_k", von_fall, 2561);
      chk("fs_count", fs_cnt, 19);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
